// File: rtl/robo_pkg.sv
// robo_pkg: shared types and helpers for the robo_atuador actuator executor.
//   state_t  - executor FSM states
//   cmd_t    - latched command selection
//   drive_t  - bundled H-bridge / arm drive levels
//   DEF_*    - default durations and counter width
package robo_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DEAD,
    ST_MOVE,
    ST_ROTATE,
    ST_ARM
  } state_t;

  typedef enum logic [1:0] {
    CMD_NONE,
    CMD_FWD,
    CMD_TURN,
    CMD_REMOVE
  } cmd_t;

  typedef struct packed {
    logic l_en;
    logic r_en;
    logic l_dir;
    logic r_dir;
    logic arm;
  } drive_t;

  localparam int DEF_FWD_CYCLES    = 50;
  localparam int DEF_TURN_CYCLES   = 100;
  localparam int DEF_REMOVE_CYCLES = 200;
  localparam int DEF_DEAD_CYCLES   = 2;
  localparam int DEF_CNT_W         = 16;

  // remove > turn > forward
  function automatic cmd_t cmd_select(input logic fwd, input logic trn, input logic rem);
    if (rem)      return CMD_REMOVE;
    else if (trn) return CMD_TURN;
    else if (fwd) return CMD_FWD;
    else          return CMD_NONE;
  endfunction

  function automatic state_t action_state(input cmd_t c);
    case (c)
      CMD_FWD:    return ST_MOVE;
      CMD_TURN:   return ST_ROTATE;
      CMD_REMOVE: return ST_ARM;
      default:    return ST_IDLE;
    endcase
  endfunction

  // Directions stay 0 unless the matching enable is 1; ROTATE spins left in place.
  function automatic drive_t drive_of(input state_t s);
    drive_t d;
    d = '0;
    case (s)
      ST_MOVE:   begin d.l_en = 1'b1; d.r_en = 1'b1; d.l_dir = 1'b1; d.r_dir = 1'b1; end
      ST_ROTATE: begin d.l_en = 1'b1; d.r_en = 1'b1; d.l_dir = 1'b0; d.r_dir = 1'b1; end
      ST_ARM:    begin d.arm  = 1'b1; end
      default:   d = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/robo_timer.sv
// robo_timer: loadable down-counter shared by the dead-time and action phases.
//   clock, reset (async, active-low)
//   load, load_val : synchronous load (wins over counting)
//   value          : current count
//   zero           : value == 0; the counter holds at 0 instead of wrapping
module robo_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] value,
  output logic             zero
);

  assign zero = (value == '0);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)     value <= '0;
    else if (load)  value <= load_val;
    else if (!zero) value <= value - CNT_W'(1);
  end

endmodule

// File: rtl/robo_atuador.sv
// robo_atuador: converts one-hot navigation commands into timed, non-overlapping
// wheel / arm drive sequences with H-bridge dead time before every action.
//   clock, reset (async, active-low)
//   forward, turn, remove          : command levels, sampled only in IDLE
//   motor_l/r_en, motor_l/r_dir    : wheel H-bridge drive (dir 1 = forward)
//   arm                            : collector arm drive
//   busy                           : state != IDLE
//   done                           : one-cycle pulse after an action completes
//   error                          : sticky multi-command flag
// Optional build macro ROBO_ATUADOR_CMD_CHECK_EN: when defined, more than one
// command high at acceptance sets error until reset; otherwise error is 0.
module robo_atuador
  import robo_pkg::*;
#(
  parameter int FWD_CYCLES    = DEF_FWD_CYCLES,
  parameter int TURN_CYCLES   = DEF_TURN_CYCLES,
  parameter int REMOVE_CYCLES = DEF_REMOVE_CYCLES,
  parameter int DEAD_CYCLES   = DEF_DEAD_CYCLES,
  parameter int CNT_W         = DEF_CNT_W
) (
  input  logic clock,
  input  logic reset,
  input  logic forward,
  input  logic turn,
  input  logic remove,
  output logic motor_l_en,
  output logic motor_r_en,
  output logic motor_l_dir,
  output logic motor_r_dir,
  output logic arm,
  output logic busy,
  output logic done,
  output logic error
);

  localparam bit               HAS_DEAD  = (DEAD_CYCLES > 0);
  localparam logic [CNT_W-1:0] DEAD_LOAD = HAS_DEAD ? CNT_W'(DEAD_CYCLES - 1) : '0;

  function automatic logic [CNT_W-1:0] dur_load(input cmd_t c);
    case (c)
      CMD_FWD:    return CNT_W'(FWD_CYCLES - 1);
      CMD_TURN:   return CNT_W'(TURN_CYCLES - 1);
      CMD_REMOVE: return CNT_W'(REMOVE_CYCLES - 1);
      default:    return '0;
    endcase
  endfunction

  state_t           state;
  cmd_t             cmd_q;
  cmd_t             sel;
  drive_t           drv;
  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic [CNT_W-1:0] tmr_value;
  logic             tmr_zero;
  logic             unused_tmr_value;

  assign unused_tmr_value = ^tmr_value;

  robo_timer #(.CNT_W(CNT_W)) u_timer (
    .clock    (clock),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .value    (tmr_value),
    .zero     (tmr_zero)
  );

  // Timer reloads coincide with the FSM edges that enter DEAD or an action,
  // so the count is always fresh and never wraps.
  always_comb begin
    sel      = cmd_select(forward, turn, remove);
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state)
      ST_IDLE: if (sel != CMD_NONE) begin
        tmr_load = 1'b1;
        tmr_val  = HAS_DEAD ? DEAD_LOAD : dur_load(sel);
      end
      ST_DEAD: if (tmr_zero) begin
        tmr_load = 1'b1;
        tmr_val  = dur_load(cmd_q);
      end
      default: ;
    endcase
  end

  // Drives are updated on the same edge as the state they belong to, so no
  // drive level ever leaks into a neighbouring state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      cmd_q <= CMD_NONE;
      drv   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: if (sel != CMD_NONE) begin
          cmd_q <= sel;
          busy  <= 1'b1;
          if (HAS_DEAD) begin
            state <= ST_DEAD;
            drv   <= '0;
          end else begin
            state <= action_state(sel);
            drv   <= drive_of(action_state(sel));
          end
        end
        ST_DEAD: if (tmr_zero) begin
          state <= action_state(cmd_q);
          drv   <= drive_of(action_state(cmd_q));
        end
        ST_MOVE, ST_ROTATE, ST_ARM: if (tmr_zero) begin
          state <= ST_IDLE;
          drv   <= '0;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        default: begin
          state <= ST_IDLE;
          drv   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign motor_l_en  = drv.l_en;
  assign motor_r_en  = drv.r_en;
  assign motor_l_dir = drv.l_dir;
  assign motor_r_dir = drv.r_dir;
  assign arm         = drv.arm;

`ifdef ROBO_ATUADOR_CMD_CHECK_EN
  logic multi;
  assign multi = (forward & turn) | (forward & remove) | (turn & remove);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                          error <= 1'b0;
    else if (state == ST_IDLE && multi)  error <= 1'b1;
  end
`else
  assign error = 1'b0;
`endif

endmodule

// File: tb/tb_robo_atuador.sv
// Scoreboard bench for robo_atuador (FWD=4, TURN=6, REMOVE=3, DEAD=2).
// Stimulus pushes per-cycle expected output vectors tagged with the cycle
// number; a monitor pops and compares them shortly after each rising edge.
// Vector layout: {busy, done, error, arm, l_en, r_en, l_dir, r_dir}.
module tb_robo_atuador;

  localparam int FWD = 4, TURN = 6, REM = 3, DEAD = 2;
`ifdef ROBO_ATUADOR_CMD_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic clock, reset, forward, turn, remove;
  logic motor_l_en, motor_r_en, motor_l_dir, motor_r_dir, arm, busy, done, error;

  robo_atuador #(
    .FWD_CYCLES(FWD), .TURN_CYCLES(TURN), .REMOVE_CYCLES(REM),
    .DEAD_CYCLES(DEAD), .CNT_W(8)
  ) dut (
    .clock(clock), .reset(reset), .forward(forward), .turn(turn), .remove(remove),
    .motor_l_en(motor_l_en), .motor_r_en(motor_r_en),
    .motor_l_dir(motor_l_dir), .motor_r_dir(motor_r_dir),
    .arm(arm), .busy(busy), .done(done), .error(error)
  );

  typedef struct {
    int         cyc;
    logic [7:0] v;
    string      nm;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  bit   err_sticky = 1'b0;

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [7:0] vec(input bit b, input bit d, input bit e, input bit a,
                                     input bit le, input bit re, input bit ld, input bit rd);
    return {b, d, e, a, le, re, ld, rd};
  endfunction

  task automatic push(input int c, input logic [7:0] v, input string nm);
    exp_t e;
    e.cyc = c; e.v = v; e.nm = nm;
    q.push_back(e);
  endtask

  // kind: 0 forward, 1 turn, 2 remove. Cycles b+1..b+D+N+1 after acceptance.
  task automatic exp_action(input int b, input int kind, input string nm);
    int n;
    n = (kind == 0) ? FWD : (kind == 1) ? TURN : REM;
    for (int k = 1; k <= DEAD; k++)
      push(b + k, vec(1, 0, err_sticky, 0, 0, 0, 0, 0), $sformatf("%s dead k%0d", nm, k));
    for (int k = DEAD + 1; k <= DEAD + n; k++) begin
      case (kind)
        0:       push(b + k, vec(1, 0, err_sticky, 0, 1, 1, 1, 1), $sformatf("%s move k%0d", nm, k));
        1:       push(b + k, vec(1, 0, err_sticky, 0, 1, 1, 0, 1), $sformatf("%s rot k%0d", nm, k));
        default: push(b + k, vec(1, 0, err_sticky, 1, 0, 0, 0, 0), $sformatf("%s arm k%0d", nm, k));
      endcase
    end
    push(b + DEAD + n + 1, vec(0, 1, err_sticky, 0, 0, 0, 0, 0), $sformatf("%s done k%0d", nm, DEAD + n + 1));
  endtask

  task automatic idle_exp(input int b, input int k0, input int k1, input string nm);
    for (int k = k0; k <= k1; k++)
      push(b + k, vec(0, 0, err_sticky, 0, 0, 0, 0, 0), $sformatf("%s idle k%0d", nm, k));
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clock);
  endtask

  // Monitor
  initial begin
    logic [7:0] act;
    exp_t       e;
    forever begin
      @(posedge clock);
      #2;
      act = {busy, done, error, arm, motor_l_en, motor_r_en, motor_l_dir, motor_r_dir};
      while (q.size() > 0 && q[0].cyc < cyc) begin
        e = q.pop_front();
        tests++; fails++;
        $display("FAIL %s: cycle %0d never sampled (now %0d)", e.nm, e.cyc, cyc);
      end
      if (q.size() > 0 && q[0].cyc == cyc) begin
        e = q.pop_front();
        tests++;
        if (act !== e.v) begin
          fails++;
          $display("FAIL %s @cyc %0d: got %b want %b (busy,done,err,arm,le,re,ld,rd)",
                   e.nm, cyc, act, e.v);
        end
      end
    end
  end

  // Stimulus
  initial begin
    int b;
    reset = 1'b0; forward = 1'b0; turn = 1'b0; remove = 1'b0;
    push(1, 8'h00, "in reset c1");
    push(2, 8'h00, "in reset c2");
    repeat (3) @(negedge clock);

    // 1: reset release, idle for 20 cycles
    b = cyc;
    reset = 1'b1;
    idle_exp(b, 1, 20, "s1");
    wait_cyc(b + 20);

    // 2: single forward pulse
    b = cyc;
    forward = 1'b1;
    exp_action(b, 0, "s2 fwd");
    idle_exp(b, 8, 9, "s2");
    @(negedge clock);
    forward = 1'b0;
    wait_cyc(b + 9);

    // 3: turn held -> back-to-back every 9 cycles
    b = cyc;
    turn = 1'b1;
    exp_action(b,      1, "s3 turn#1");
    exp_action(b + 9,  1, "s3 turn#2");
    exp_action(b + 18, 1, "s3 turn#3");
    idle_exp(b, 28, 30, "s3");
    wait_cyc(b + 20);
    turn = 1'b0;
    wait_cyc(b + 30);

    // 4: forward + remove -> remove wins, error if checking built
    b = cyc;
    forward = 1'b1; remove = 1'b1;
    err_sticky = CHK;
    exp_action(b, 2, "s4 multi");
    idle_exp(b, 7, 8, "s4");
    @(negedge clock);
    forward = 1'b0; remove = 1'b0;
    wait_cyc(b + 8);

    // 5: remove, then a short async reset pulse mid-ARM (between edges)
    b = cyc;
    remove = 1'b1;
    push(b + 1, vec(1, 0, err_sticky, 0, 0, 0, 0, 0), "s5 dead k1");
    push(b + 2, vec(1, 0, err_sticky, 0, 0, 0, 0, 0), "s5 dead k2");
    push(b + 3, vec(1, 0, err_sticky, 1, 0, 0, 0, 0), "s5 arm k3");
    push(b + 4, vec(1, 0, err_sticky, 1, 0, 0, 0, 0), "s5 arm k4");
    err_sticky = 1'b0;
    idle_exp(b, 5, 12, "s5 after reset");
    @(negedge clock);
    remove = 1'b0;
    wait_cyc(b + 4);
    reset = 1'b0;
    #3;
    reset = 1'b1;
    wait_cyc(b + 12);

    b = cyc;
    forward = 1'b1;
    exp_action(b, 0, "s5 fwd");
    idle_exp(b, 8, 9, "s5b");
    @(negedge clock);
    forward = 1'b0;
    wait_cyc(b + 9);

    // 6: turn while busy with forward is ignored
    b = cyc;
    forward = 1'b1;
    exp_action(b, 0, "s6 fwd");
    idle_exp(b, 8, 12, "s6");
    @(negedge clock);
    forward = 1'b0;
    wait_cyc(b + 3);
    turn = 1'b1;
    wait_cyc(b + 6);
    turn = 1'b0;
    wait_cyc(b + 12);

    for (int i = 0; i < 50 && q.size() > 0; i++) @(negedge clock);
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, want finish");
    $fatal(1, "timeout");
  end

endmodule
